// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared opcode / sub-opcode constants, flag bit positions and
//             enumerated types for the sequential ALU control block.
//  Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

   // Simplified function codes
   localparam logic [4:0] OP_ARITH = 5'b00000;
   localparam logic [4:0] OP_CMP   = 5'b00110;
   localparam logic [4:0] OP_SUBI  = 5'b01000;
   localparam logic [4:0] OP_SHL   = 5'b01001;
   localparam logic [4:0] OP_SHR   = 5'b01010;
   localparam logic [4:0] OP_SAR   = 5'b01011;

   // ALU sub-opcodes, meaningful only with OP_ARITH
   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_ADC = 2'b01;
   localparam logic [1:0] ALU_SBB = 2'b10;
   localparam logic [1:0] ALU_SUB = 2'b11;

   // Bit positions inside the {N,Z,C,V} flag vector
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   // Control FSM states
   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   // Iterative shifter direction / fill mode
   typedef enum logic [1:0] {
      SH_LEFT      = 2'b00,
      SH_RIGHT_LOG = 2'b01,
      SH_RIGHT_ARI = 2'b10
   } shift_kind_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_ctrl_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_ctrl_seq_if
//  Purpose  : Request/response bundle between the register-read stage
//             (master) and the sequential ALU (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface alu_ctrl_seq_if #(
   parameter int DATA_W = 16
) ();

   logic              in_valid;
   logic              in_ready;
   logic [4:0]        opcode;
   logic [1:0]        alu_op;
   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;
   logic              out_valid;
   logic [DATA_W-1:0] result;
   logic              wb_en;
   logic              illegal;
   logic [3:0]        flags;

   modport master (
      output in_valid, opcode, alu_op, a, b,
      input  in_ready, out_valid, result, wb_en, illegal, flags
   );

   modport slave (
      input  in_valid, opcode, alu_op, a, b,
      output in_ready, out_valid, result, wb_en, illegal, flags
   );

endinterface : alu_ctrl_seq_if
`default_nettype wire

// File: rtl/alu_shift_iter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_shift_iter
//  Purpose  : One-bit-per-cycle shifter with a down-counter. A start pulse
//             loads source and amount; done flags the cycle whose clock edge
//             performs the final shift, with that shift's result and the bit
//             it pushes out presented combinationally so the owner can
//             register them on the same edge.
//  Revision : 1.0  initial release
// ============================================================================
module alu_shift_iter
   import alu_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int CNT_W  = $clog2(DATA_W) + 1
) (
   input  wire logic              clk,
   input  wire logic              rst,
   input  wire logic              start,
   input  wire shift_kind_t       kind,
   input  wire logic [DATA_W-1:0] src,
   input  wire logic [CNT_W-1:0]  amount,
   output logic                   done,
   output logic [DATA_W-1:0]      result,
   output logic                   carry
);

   logic [DATA_W-1:0] r_sr;
   logic [CNT_W-1:0]  r_cnt;
   shift_kind_t       r_kind;
   logic [DATA_W-1:0] w_step;
   logic              w_out_bit;

   // One-bit step of the held value and the bit it pushes out
   always_comb begin
      w_step    = {1'b0, r_sr[DATA_W-1:1]};
      w_out_bit = r_sr[0];
      case (r_kind)
         SH_LEFT: begin
            w_step    = {r_sr[DATA_W-2:0], 1'b0};
            w_out_bit = r_sr[DATA_W-1];
         end
         SH_RIGHT_ARI: begin
            w_step    = {r_sr[DATA_W-1], r_sr[DATA_W-1:1]};
            w_out_bit = r_sr[0];
         end
         default: begin
            w_step    = {1'b0, r_sr[DATA_W-1:1]};
            w_out_bit = r_sr[0];
         end
      endcase
   end

   assign done   = (r_cnt == CNT_W'(1));
   assign result = w_step;
   assign carry  = w_out_bit;

   // Load on start, otherwise shift while the counter is non-zero
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sr   <= '0;
         r_cnt  <= '0;
         r_kind <= SH_LEFT;
      end else if (start) begin
         r_sr   <= src;
         r_cnt  <= amount;
         r_kind <= kind;
      end else if (r_cnt != '0) begin
         r_sr   <= w_step;
         r_cnt  <= r_cnt - CNT_W'(1);
      end
   end

endmodule : alu_shift_iter
`default_nettype wire

// File: rtl/alu_ctrl_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_ctrl_seq
//  Purpose  : Sequential ALU control: opcode decode, add/subtract datapath,
//             architectural {N,Z,C,V} flag register and an iterative shifter
//             behind a valid/ready request and a one-cycle result pulse.
//  Revision : 1.0  initial release
// ============================================================================
module alu_ctrl_seq
   import alu_pkg::*;
#(
   parameter int         DATA_W   = 16,
   parameter logic [3:0] FLAG_RST = 4'b0000
) (
   input  wire logic     clk,
   input  wire logic     rst,
   alu_ctrl_seq_if.slave bus
);

   localparam int               CNT_W   = $clog2(DATA_W) + 1;
   localparam logic [CNT_W-1:0] C_MAX_K = CNT_W'(DATA_W);

   state_t            r_state;
   state_t            w_state_nxt;
   logic              w_in_ready;
   logic              w_accept;
   logic              w_sh_start;
   logic              w_sh_done;
   logic [DATA_W-1:0] w_sh_result;
   logic              w_sh_carry;

   // Decode outputs
   logic              w_is_add;
   logic              w_is_shift;
   logic              w_inv_b;
   logic              w_cin;
   logic              w_wb;
   logic              w_illegal;
   shift_kind_t       w_kind;

   // Datapath
   logic [DATA_W-1:0] w_b_eff;
   logic [DATA_W:0]   w_sum;
   logic [CNT_W-1:0]  w_k;
   logic [DATA_W-1:0] w_res;
   logic [3:0]        w_flags_nxt;

   // Registered outputs
   logic              r_out_valid;
   logic [DATA_W-1:0] r_result;
   logic              r_wb_en;
   logic              r_illegal;
   logic [3:0]        r_flags;

   assign w_accept   = bus.in_valid & w_in_ready;
   assign w_sh_start = w_accept & w_is_shift & (w_k != '0);

   // Opcode decode into datapath controls
   always_comb begin
      w_is_add   = 1'b0;
      w_is_shift = 1'b0;
      w_inv_b    = 1'b0;
      w_cin      = 1'b0;
      w_wb       = 1'b0;
      w_illegal  = 1'b0;
      w_kind     = SH_LEFT;
      case (bus.opcode)
         OP_ARITH: begin
            w_is_add = 1'b1;
            w_wb     = 1'b1;
            case (bus.alu_op)
               ALU_ADC: w_cin = r_flags[FLAG_C];
               ALU_SBB: begin
                  w_inv_b = 1'b1;
                  w_cin   = r_flags[FLAG_C];
               end
               ALU_SUB: begin
                  w_inv_b = 1'b1;
                  w_cin   = 1'b1;
               end
               default: w_cin = 1'b0;
            endcase
         end
         OP_CMP, OP_SUBI: begin
            w_is_add = 1'b1;
            w_inv_b  = 1'b1;
            w_cin    = 1'b1;
            w_wb     = (bus.opcode == OP_SUBI);
         end
         OP_SHL: begin
            w_is_shift = 1'b1;
            w_wb       = 1'b1;
            w_kind     = SH_LEFT;
         end
         OP_SHR: begin
            w_is_shift = 1'b1;
            w_wb       = 1'b1;
            w_kind     = SH_RIGHT_LOG;
         end
         OP_SAR: begin
            w_is_shift = 1'b1;
            w_wb       = 1'b1;
            w_kind     = SH_RIGHT_ARI;
         end
         default: w_illegal = 1'b1;
      endcase
   end

   // Single-cycle result and flags (arithmetic, zero-length shift, illegal)
   always_comb begin
      w_b_eff     = w_inv_b ? ~bus.b : bus.b;
      w_sum       = {1'b0, bus.a} + {1'b0, w_b_eff} + (DATA_W+1)'(w_cin);
      w_k         = (bus.b[CNT_W-1:0] > C_MAX_K) ? C_MAX_K : bus.b[CNT_W-1:0];
      w_res       = '0;
      w_flags_nxt = r_flags;
      if (w_is_add) begin
         w_res               = w_sum[DATA_W-1:0];
         w_flags_nxt[FLAG_N] = w_sum[DATA_W-1];
         w_flags_nxt[FLAG_Z] = (w_sum[DATA_W-1:0] == '0);
         w_flags_nxt[FLAG_C] = w_sum[DATA_W];
         // Overflow: operands agree in sign but the sum does not
         w_flags_nxt[FLAG_V] = (bus.a[DATA_W-1] == w_b_eff[DATA_W-1]) &&
                               (w_sum[DATA_W-1] != bus.a[DATA_W-1]);
      end else if (w_is_shift) begin
         // Only reached for k=0 registration: value passes, C and V kept
         w_res               = bus.a;
         w_flags_nxt[FLAG_N] = bus.a[DATA_W-1];
         w_flags_nxt[FLAG_Z] = (bus.a == '0);
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // FSM next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_sh_start) w_state_nxt = ST_SHIFT;
         ST_SHIFT: if (w_sh_done)  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      w_in_ready = (r_state == ST_IDLE);
   end

   alu_shift_iter #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) u_shift (
      .clk    (clk),
      .rst    (rst),
      .start  (w_sh_start),
      .kind   (w_kind),
      .src    (bus.a),
      .amount (w_k),
      .done   (w_sh_done),
      .result (w_sh_result),
      .carry  (w_sh_carry)
   );

   // Result / flag registers: single-cycle ops on accept, shifts on done
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_wb_en     <= 1'b0;
         r_illegal   <= 1'b0;
         r_flags     <= FLAG_RST;
      end else begin
         r_out_valid <= 1'b0;
         if (w_accept && !w_sh_start) begin
            r_out_valid <= 1'b1;
            r_result    <= w_res;
            r_wb_en     <= w_wb;
            r_illegal   <= w_illegal;
            r_flags     <= w_flags_nxt;
         end else if (w_sh_done) begin
            r_out_valid     <= 1'b1;
            r_result        <= w_sh_result;
            r_wb_en         <= 1'b1;
            r_illegal       <= 1'b0;
            r_flags[FLAG_N] <= w_sh_result[DATA_W-1];
            r_flags[FLAG_Z] <= (w_sh_result == '0);
            r_flags[FLAG_C] <= w_sh_carry;
         end
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.result    = r_result;
   assign bus.wb_en     = r_wb_en;
   assign bus.illegal   = r_illegal;
   assign bus.flags     = r_flags;

endmodule : alu_ctrl_seq
`default_nettype wire

// File: tb/tb_alu_ctrl_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_ctrl_seq
//  Purpose  : Self-checking bench for alu_ctrl_seq with a behavioural model
//             of results, flags and latency.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_ctrl_seq;

   localparam int         W          = 16;
   localparam logic [3:0] C_FLAG_RST = 4'b0000;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   logic [3:0] exp_flags;

   alu_ctrl_seq_if #(.DATA_W(W)) bus ();

   alu_ctrl_seq #(
      .DATA_W   (W),
      .FLAG_RST (C_FLAG_RST)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference model: arithmetic on wide integers, shifts via operators
   function automatic void model(input logic [4:0] op, input logic [1:0] aop,
                                 input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [3:0] fl,
                                 output logic [W-1:0] res, output logic wb,
                                 output logic ill, output logic [3:0] fo,
                                 output int lat);
      logic [W-1:0] beff;
      longint       s, sa, sb, ss;
      int           cin, k;
      bit           inv, arith;
      res = '0; wb = 1'b0; ill = 1'b0; fo = fl; lat = 1;
      arith = 0; inv = 0; cin = 0;
      if (op == 5'b00000) begin
         arith = 1; wb = 1'b1;
         case (aop)
            2'd0: cin = 0;
            2'd1: cin = int'(fl[1]);
            2'd2: begin inv = 1; cin = int'(fl[1]); end
            default: begin inv = 1; cin = 1; end
         endcase
      end else if (op == 5'b00110) begin
         arith = 1; inv = 1; cin = 1;
      end else if (op == 5'b01000) begin
         arith = 1; wb = 1'b1; inv = 1; cin = 1;
      end else if (op == 5'b01001 || op == 5'b01010 || op == 5'b01011) begin
         wb = 1'b1;
         k = int'(b[4:0]);
         if (k > W) k = W;
         lat = k + 1;
         if (k == 0) res = a;
         else if (op == 5'b01001) begin res = a << k; fo[1] = a[W-k]; end
         else if (op == 5'b01010) begin res = a >> k; fo[1] = a[k-1]; end
         else begin res = $signed(a) >>> k; fo[1] = a[k-1]; end
         fo[3] = res[W-1];
         fo[2] = (res == '0);
      end else begin
         ill = 1'b1;
      end
      if (arith) begin
         beff = inv ? ~b : b;
         s = longint'(a) + longint'(beff) + longint'(cin);
         res = s[W-1:0];
         sa = a[W-1] ? longint'(a) - (longint'(1) << W) : longint'(a);
         sb = beff[W-1] ? longint'(beff) - (longint'(1) << W) : longint'(beff);
         ss = sa + sb + longint'(cin);
         fo[3] = res[W-1];
         fo[2] = (res == '0);
         fo[1] = s[W];
         fo[0] = (ss > ((longint'(1) << (W-1)) - 1)) || (ss < -(longint'(1) << (W-1)));
      end
   endfunction

   // Issue one request, wait for its result, check everything
   task automatic run_op(input string name, input logic [4:0] op, input logic [1:0] aop,
                         input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] er;
      logic         ewb, eill, rdy_bad;
      logic [3:0]   ef;
      int           elat, cyc, guard;
      model(op, aop, a, b, exp_flags, er, ewb, eill, ef, elat);
      bus.opcode = op; bus.alu_op = aop; bus.a = a; bus.b = b; bus.in_valid = 1'b1;
      guard = 0;
      while (bus.in_ready !== 1'b1 && guard < 50) begin
         @(posedge clk); #1; guard++;
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      cyc = 1; rdy_bad = 1'b0;
      while (bus.out_valid !== 1'b1 && cyc < 40) begin
         if (bus.in_ready !== 1'b0) rdy_bad = 1'b1;
         @(posedge clk); #1; cyc++;
      end
      checks++;
      if (cyc !== elat) begin errors++; $display("FAIL %s latency: got %0d want %0d", name, cyc, elat); end
      if (elat > 1) begin
         checks++;
         if (rdy_bad !== 1'b0) begin errors++; $display("FAIL %s in_ready high during shift", name); end
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL %s in_ready at result: got %b want 1", name, bus.in_ready); end
      checks++;
      if (bus.result !== er) begin errors++; $display("FAIL %s result: got %h want %h", name, bus.result, er); end
      checks++;
      if (bus.wb_en !== ewb) begin errors++; $display("FAIL %s wb_en: got %b want %b", name, bus.wb_en, ewb); end
      checks++;
      if (bus.illegal !== eill) begin errors++; $display("FAIL %s illegal: got %b want %b", name, bus.illegal, eill); end
      checks++;
      if (bus.flags !== ef) begin errors++; $display("FAIL %s flags: got %b want %b", name, bus.flags, ef); end
      exp_flags = ef;
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.result !== er) begin
         errors++;
         $display("FAIL %s pulse/hold: out_valid=%b result=%h want 0/%h", name, bus.out_valid, bus.result, er);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; bus.in_valid = 1'b0; bus.opcode = '0; bus.alu_op = '0; bus.a = '0; bus.b = '0;
      repeat (3) @(posedge clk);
      #1; rst = 1'b0;
      exp_flags = C_FLAG_RST;
      checks++;
      if ({bus.out_valid, bus.wb_en, bus.illegal, bus.in_ready} !== 4'b0001) begin
         errors++;
         $display("FAIL reset ctrl: got ov/wb/ill/rdy=%b want 0001",
                  {bus.out_valid, bus.wb_en, bus.illegal, bus.in_ready});
      end
      checks++;
      if (bus.result !== '0) begin errors++; $display("FAIL reset result: got %h want 0", bus.result); end
      checks++;
      if (bus.flags !== C_FLAG_RST) begin errors++; $display("FAIL reset flags: got %b want %b", bus.flags, C_FLAG_RST); end
   endtask

   // ADD then ADC accepted on consecutive edges
   task automatic test_back_to_back();
      bus.opcode = 5'b00000; bus.alu_op = 2'b00; bus.a = 16'hFFFF; bus.b = 16'h0001; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.alu_op = 2'b01; bus.a = 16'h0001; bus.b = 16'h0001;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.result !== 16'h0000 || bus.wb_en !== 1'b1 || bus.flags !== 4'b0110) begin
         errors++;
         $display("FAIL b2b add: ov=%b res=%h wb=%b flags=%b want 1/0000/1/0110",
                  bus.out_valid, bus.result, bus.wb_en, bus.flags);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.result !== 16'h0003 || bus.flags !== 4'b0000) begin
         errors++;
         $display("FAIL b2b adc: ov=%b res=%h flags=%b want 1/0003/0000",
                  bus.out_valid, bus.result, bus.flags);
      end
      exp_flags = 4'b0000;
      @(posedge clk); #1;
   endtask

   task automatic test_arith();
      run_op("sub",     5'b00000, 2'b11, 16'h0003, 16'h0005);
      run_op("sbb",     5'b00000, 2'b10, 16'h0010, 16'h0001);
      run_op("cmp",     5'b00110, 2'b00, 16'h8000, 16'h0001);
      run_op("illegal", 5'b11111, 2'b00, 16'h1234, 16'h5678);
      run_op("subi",    5'b01000, 2'b00, 16'h7FFF, 16'hFFFF);
   endtask

   task automatic test_shift();
      run_op("shl3",  5'b01001, 2'b00, 16'h8001, 16'h0003);
      run_op("sar16", 5'b01011, 2'b00, 16'h8000, 16'h0014);
      run_op("shr0",  5'b01010, 2'b00, 16'hA5A5, 16'h0000);
      run_op("shr1",  5'b01010, 2'b00, 16'h0001, 16'h0001);
      run_op("shl16", 5'b01001, 2'b00, 16'hFFFF, 16'h0010);
   endtask

   // Reset arriving mid-shift aborts it
   task automatic test_reset_abort();
      logic seen;
      run_op("cmp_pre", 5'b00110, 2'b00, 16'h8000, 16'h0001);
      bus.opcode = 5'b01010; bus.alu_op = 2'b00; bus.a = 16'hFFFF; bus.b = 16'h0008; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      seen = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         if (bus.out_valid === 1'b1) seen = 1'b1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_flags = C_FLAG_RST;
      checks++;
      if (seen !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL abort out_valid: seen=%b now=%b want 0", seen, bus.out_valid); end
      checks++;
      if (bus.flags !== C_FLAG_RST) begin errors++; $display("FAIL abort flags: got %b want %b", bus.flags, C_FLAG_RST); end
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL abort in_ready: got %b want 1", bus.in_ready); end
      seen = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
         if (bus.out_valid === 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin errors++; $display("FAIL abort late out_valid: got 1 want 0"); end
      run_op("add_post", 5'b00000, 2'b00, 16'h1234, 16'h4321);
   endtask

   task automatic test_random();
      logic [4:0] op;
      logic [1:0] aop;
      logic [4:0] codes [5];
      codes = '{5'b00110, 5'b01000, 5'b01001, 5'b01010, 5'b01011};
      for (int i = 0; i < 80; i++) begin
         aop = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 7))
            0, 1, 2: op = 5'b00000;
            3:       begin
                        op = 5'($urandom_range(0, 31));
                        while (op == 5'b00000 || op == 5'b00110 || (op >= 5'b01000 && op <= 5'b01011))
                           op = 5'($urandom_range(0, 31));
                     end
            default: op = codes[$urandom_range(0, 4)];
         endcase
         run_op("random", op, aop, 16'($urandom), 16'($urandom));
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_back_to_back();
      test_arith();
      test_shift();
      test_reset_abort();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_alu_ctrl_seq
`default_nettype wire
